// File: rtl/elastic_pipe_reg_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Width needed to count 0..depth valid stages inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_stage.sv
// One elastic stage: a valid bit plus data word that loads whenever it is empty
// or its downstream neighbour is moving.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  assign ready = ~valid | dn_ready;

  // Data only moves with a valid word so bubbles never overwrite held data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else begin
      if (clr) begin
        valid <= 1'b0;
      end else if (ready) begin
        valid <= up_valid;
      end
      if (!clr && ready && up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage valid/ready register pipeline that collapses bubbles, with
// synchronous flush and an occupancy count.
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] dn_r;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] up_d   [DEPTH];

  assign up_v[0]       = in_valid & ~flush;
  assign up_d[0]       = in_data;
  assign dn_r[DEPTH-1] = out_ready;

  for (genvar i = 1; i < DEPTH; i++) begin : g_link
    assign up_v[i]   = valid_q[i-1];
    assign up_d[i]   = data_q[i-1];
    assign dn_r[i-1] = rdy[i];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (flush),
      .up_valid(up_v[i]),
      .up_data (up_d[i]),
      .dn_ready(dn_r[i]),
      .valid   (valid_q[i]),
      .data    (data_q[i]),
      .ready   (rdy[i])
    );
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(valid_q[i]);
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: three configurations checked every cycle against a
// queue model where each word has an earliest-visible cycle at the output.
module tb_elastic_pipe_reg;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic iv [3];
  logic ordy [3];
  logic fl [3];
  logic ir [3];
  logic ov [3];

  logic [7:0]  id0;
  logic [0:0]  id1;
  logic [15:0] id2;
  logic [7:0]  od0;
  logic [0:0]  od1;
  logic [15:0] od2;
  logic [2:0]  oc0;
  logic [0:0]  oc1;
  logic [2:0]  oc2;

  logic        s_ir [3];
  logic        s_ov [3];
  logic [15:0] s_od [3];
  int          s_oc [3];

  logic [15:0] mdata [3][16];
  int          mrdy  [3][16];
  int          mhead [3];
  int          mcnt  [3];
  int          cyc;

  int passed;
  int total;

  always #5 clock = ~clock;

  elastic_pipe_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) u_dut (
    .clock(clock), .reset_n(reset_n), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .occupancy(oc0)
  );

  elastic_pipe_reg #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_d1 (
    .clock(clock), .reset_n(reset_n), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .occupancy(oc1)
  );

  elastic_pipe_reg #(.WIDTH(16), .DEPTH(7), .RESET_VAL(16'h0000)) u_d7 (
    .clock(clock), .reset_n(reset_n), .flush(fl[2]),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id2),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .occupancy(oc2)
  );

  function automatic int dep(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  function automatic logic [15:0] wmask(input int k);
    case (k)
      0:       return 16'h00FF;
      1:       return 16'h0001;
      default: return 16'hFFFF;
    endcase
  endfunction

  function automatic logic [15:0] get_od(input int k);
    case (k)
      0:       return {8'h00, od0};
      1:       return {15'h0000, od1};
      default: return od2;
    endcase
  endfunction

  function automatic int get_oc(input int k);
    case (k)
      0:       return int'(oc0);
      1:       return int'(oc1);
      default: return int'(oc2);
    endcase
  endfunction

  function automatic logic [15:0] get_id(input int k);
    case (k)
      0:       return {8'h00, id0};
      1:       return {15'h0000, id1};
      default: return id2;
    endcase
  endfunction

  task automatic set_id(input int k, input logic [15:0] v);
    case (k)
      0:       id0 = v[7:0];
      1:       id1 = v[0:0];
      default: id2 = v;
    endcase
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
      fl[k]   = 1'b0;
      set_id(k, 16'h0000);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mcnt[k]  = 0;
      mhead[k] = 0;
    end
  endtask

  // One clock cycle: sample and compare every instance on the falling edge,
  // advance the model with this cycle's transfers, then step past the rising edge.
  task automatic step();
    int   h;
    int   t;
    logic exp_ir;
    logic exp_ov;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      h      = mhead[k];
      exp_ir = !fl[k] && ((mcnt[k] < dep(k)) || ordy[k]);
      exp_ov = (mcnt[k] > 0) && (cyc >= mrdy[k][h]);
      s_ir[k] = ir[k];
      s_ov[k] = ov[k];
      s_od[k] = get_od(k);
      s_oc[k] = get_oc(k);

      total++;
      if (s_ir[k] !== exp_ir)
        $display("[TB] FAIL in_ready inst%0d cyc%0d: got %b want %b", k, cyc, s_ir[k], exp_ir);
      else passed++;
      total++;
      if (s_ov[k] !== exp_ov)
        $display("[TB] FAIL out_valid inst%0d cyc%0d: got %b want %b", k, cyc, s_ov[k], exp_ov);
      else passed++;
      total++;
      if (s_oc[k] !== mcnt[k])
        $display("[TB] FAIL occupancy inst%0d cyc%0d: got %0d want %0d", k, cyc, s_oc[k], mcnt[k]);
      else passed++;
      if (exp_ov) begin
        total++;
        if (s_od[k] !== mdata[k][h])
          $display("[TB] FAIL out_data inst%0d cyc%0d: got %h want %h", k, cyc, s_od[k], mdata[k][h]);
        else passed++;
      end

      if (reset_n) begin
        if (exp_ov && ordy[k]) begin
          mhead[k] = (mhead[k] + 1) % 16;
          mcnt[k]  = mcnt[k] - 1;
          if (mcnt[k] > 0 && mrdy[k][mhead[k]] < cyc + 1)
            mrdy[k][mhead[k]] = cyc + 1;
        end
        if (fl[k]) begin
          mcnt[k] = 0;
        end else if (iv[k] && exp_ir) begin
          t = (mhead[k] + mcnt[k]) % 16;
          mdata[k][t] = get_id(k) & wmask(k);
          mrdy[k][t]  = cyc + dep(k);
          mcnt[k]     = mcnt[k] + 1;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [7:0] word;
    idle_all();
    step();
    step();
    reset_n = 1'b1;
    step();
    total++;
    if (s_ov[0] !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", s_ov[0]); else passed++;
    total++;
    if (s_oc[0] !== 0) $display("[TB] FAIL reset_occupancy: got %0d want 0", s_oc[0]); else passed++;
    total++;
    if (s_od[0] !== 16'h005A) $display("[TB] FAIL reset_out_data: got %h want 005a", s_od[0]); else passed++;
    total++;
    if (s_ir[0] !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", s_ir[0]); else passed++;

    word = 8'h11;
    iv[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      set_id(0, {8'h00, word});
      step();
      word = word + 8'h11;
    end
    iv[0] = 1'b0;
    for (int n = 0; n < 4; n++) step();
    total++;
    if (s_oc[0] !== 3) $display("[TB] FAIL preload_occupancy: got %0d want 3", s_oc[0]); else passed++;

    reset_n = 1'b0;
    #1;
    total++;
    if (ov[0] !== 1'b0) $display("[TB] FAIL async_reset_out_valid: got %b want 0", ov[0]); else passed++;
    total++;
    if (oc0 !== 3'd0) $display("[TB] FAIL async_reset_occupancy: got %0d want 0", oc0); else passed++;
    total++;
    if (od0 !== 8'h5A) $display("[TB] FAIL async_reset_out_data: got %h want 5a", od0); else passed++;
    model_clear();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    int         offer;
    int         first;
    int         nvalid;
    logic [15:0] seen;
    idle_all();
    ordy[0] = 1'b1;
    iv[0]   = 1'b1;
    set_id(0, 16'h00A5);
    offer = cyc;
    step();
    iv[0] = 1'b0;
    first  = -1;
    nvalid = 0;
    seen   = 16'h0000;
    for (int n = 0; n < 10; n++) begin
      step();
      if (s_ov[0]) begin
        if (first < 0) begin
          first = cyc - 1;
          seen  = s_od[0];
        end
        nvalid++;
      end
    end
    total++;
    if (first - offer !== 4) $display("[TB] FAIL latency_cycles: got %0d want 4", first - offer); else passed++;
    total++;
    if (nvalid !== 1) $display("[TB] FAIL latency_valid_width: got %0d want 1", nvalid); else passed++;
    total++;
    if (seen !== 16'h00A5) $display("[TB] FAIL latency_data: got %h want 00a5", seen); else passed++;
  endtask

  task automatic test_back_pressure();
    int word;
    int accepted;
    int expect_w;
    int gaps;
    int bad;
    bit started;
    idle_all();
    word = 1;
    accepted = 0;
    for (int n = 0; n < 8; n++) begin
      iv[0] = (word <= 6);
      set_id(0, 16'(word));
      step();
      if (s_ir[0] && iv[0]) begin
        word++;
        accepted++;
      end
    end
    total++;
    if (accepted !== 4) $display("[TB] FAIL stall_accepts: got %0d want 4", accepted); else passed++;
    total++;
    if (s_oc[0] !== 4) $display("[TB] FAIL stall_occupancy: got %0d want 4", s_oc[0]); else passed++;
    total++;
    if (s_ir[0] !== 1'b0) $display("[TB] FAIL stall_in_ready: got %b want 0", s_ir[0]); else passed++;

    ordy[0]  = 1'b1;
    expect_w = 1;
    gaps     = 0;
    bad      = 0;
    started  = 1'b0;
    for (int n = 0; n < 40 && expect_w <= 6; n++) begin
      iv[0] = (word <= 6);
      set_id(0, 16'(word));
      step();
      if (s_ir[0] && iv[0]) word++;
      if (s_ov[0]) begin
        if (s_od[0] !== 16'(expect_w)) bad++;
        expect_w++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
    end
    iv[0] = 1'b0;
    total++;
    if (expect_w !== 7) $display("[TB] FAIL release_count: got %0d want 7", expect_w); else passed++;
    total++;
    if (bad !== 0) $display("[TB] FAIL release_order: got %0d wrong want 0", bad); else passed++;
    total++;
    if (gaps !== 0) $display("[TB] FAIL release_gaps: got %0d want 0", gaps); else passed++;
  endtask

  task automatic test_full_rate();
    int stalls;
    int occbad;
    int outs;
    int orderbad;
    idle_all();
    ordy[0]  = 1'b1;
    stalls   = 0;
    occbad   = 0;
    outs     = 0;
    orderbad = 0;
    for (int n = 0; n < 112; n++) begin
      iv[0] = (n < 100);
      set_id(0, 16'((n + 1) & 8'hFF));
      step();
      if (n < 100 && !s_ir[0]) stalls++;
      if (n >= 4 && n < 100 && s_oc[0] != 4) occbad++;
      if (s_ov[0]) begin
        outs++;
        if (s_od[0] !== 16'(outs & 8'hFF)) orderbad++;
      end
    end
    iv[0] = 1'b0;
    total++;
    if (stalls !== 0) $display("[TB] FAIL fullrate_stalls: got %0d want 0", stalls); else passed++;
    total++;
    if (occbad !== 0) $display("[TB] FAIL fullrate_occupancy: got %0d bad cycles want 0", occbad); else passed++;
    total++;
    if (outs !== 100) $display("[TB] FAIL fullrate_outputs: got %0d want 100", outs); else passed++;
    total++;
    if (orderbad !== 0) $display("[TB] FAIL fullrate_order: got %0d wrong want 0", orderbad); else passed++;
  endtask

  task automatic test_flush();
    int leaked;
    idle_all();
    iv[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      set_id(0, 16'(8'hC0 + n));
      step();
    end
    iv[0] = 1'b0;
    step();
    step();
    fl[0] = 1'b1;
    iv[0] = 1'b1;
    set_id(0, 16'h00EE);
    step();
    total++;
    if (s_ir[0] !== 1'b0) $display("[TB] FAIL flush_in_ready: got %b want 0", s_ir[0]); else passed++;
    fl[0] = 1'b0;
    iv[0] = 1'b0;
    step();
    total++;
    if (s_oc[0] !== 0) $display("[TB] FAIL flush_occupancy: got %0d want 0", s_oc[0]); else passed++;
    ordy[0] = 1'b1;
    leaked  = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (s_ov[0]) leaked++;
    end
    total++;
    if (leaked !== 0) $display("[TB] FAIL flush_leak: got %0d words want 0", leaked); else passed++;
  endtask

  task automatic test_random();
    int pin;
    int pout;
    idle_all();
    for (int n = 0; n < 3000; n++) begin
      pin  = 25 + 25 * ((n / 500) % 3);
      pout = 75 - 25 * ((n / 250) % 3);
      for (int k = 0; k < 3; k++) begin
        iv[k]   = ($urandom_range(99) < pin);
        ordy[k] = ($urandom_range(99) < pout);
        fl[k]   = ($urandom_range(79) == 0);
        set_id(k, 16'($urandom));
      end
      step();
    end
    idle_all();
    for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
    for (int n = 0; n < 12; n++) step();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    passed = 0;
    total  = 0;
    cyc    = 0;
    model_clear();
    idle_all();
    test_reset();
    test_latency();
    test_back_pressure();
    test_full_rate();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
